arbiter_rr_8: RTL and testbench
===============================

# arbiter_rr_8

Round-robin arbiter sharing one downstream resource among 8 requesters, producing a registered one-hot grant and its 3-bit binary index (the 8:3-encoded form of the grant). It sits between the request lines and the shared datapath, sequences exclusive ownership with a release handshake, and bounds ownership time with a hold timeout so no requester can starve the others.

## Interface
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; legal range 2..255
- HOLD_W, 8, width of hold counter; must satisfy 2^HOLD_W > MAX_HOLD
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_en  input  1  arbiter enable; low forces release and blocks new grants
- i_req  input  8  request vector, bit n = requester n, level-sensitive
- i_release  input  1  current owner finished; ends grant
- o_gnt  output  8  one-hot grant, all-zero when no owner
- o_gnt_idx  output  3  binary index of granted requester; 0 when no owner
- o_gnt_valid  output  1  high exactly when o_gnt is non-zero
- o_timeout  output  1  one-cycle pulse: previous grant ended by hold limit

## Operation
- Two states: IDLE, GRANT. Reset state IDLE.
- Reset values: o_gnt=8'h00, o_gnt_idx=3'd0, o_gnt_valid=0, o_timeout=0, hold counter=0, last-winner pointer=3'd7 (first search starts at requester 0).
- IDLE: if i_en=1 and i_req!=0, pick winner = first set bit of i_req searching upward from (pointer+1) mod 8, wrapping 7->0. Next cycle: GRANT, o_gnt=one-hot(winner), o_gnt_idx=winner, o_gnt_valid=1, pointer<=winner, hold counter<=0. Otherwise stay IDLE, outputs zero.
- GRANT: hold counter increments each GRANT cycle (saturates at MAX_HOLD-1; never wraps). Exit to IDLE at next edge when any of, in priority order:
  1. i_en=0
  2. i_release=1
  3. i_req[owner]=0 (owner dropped request)
  4. hold counter == MAX_HOLD-1 (timeout)
- o_timeout=1 in the first IDLE cycle only if reason 4 was the sole exit reason; otherwise 0. Never asserted in GRANT.
- Exit always passes through at least one IDLE cycle with all grant outputs zero (bus turnaround); no back-to-back grants.
- Requests from non-owners during GRANT are ignored; they are evaluated in the IDLE cycle after exit, using the updated pointer, so the just-served requester has lowest priority.
- Pointer changes only on grant entry; timeout, release and i_en drop leave it unchanged after entry.
- o_gnt, o_gnt_idx, o_gnt_valid always mutually consistent; at most one bit of o_gnt set.

## Timing
- Arbitration latency: request sampled in IDLE at edge k, grant visible after edge k (1 cycle).
- Grant duration: 1..MAX_HOLD cycles; release sampled at edge k drops grant after edge k.
- Minimum request-to-request grant spacing: owner's grant cycles + 1 IDLE cycle.
- o_timeout: registered, high for exactly one cycle, coincident with first IDLE cycle.
- i_rst asserted mid-GRANT: all outputs zero immediately (asynchronous), pointer back to 7; first grant after deassertion goes to lowest set request bit from 0.
- i_en low in IDLE: no grant regardless of i_req; pointer held.
- i_req all zero in IDLE: remain IDLE, no pointer change.
- Simultaneous i_release and timeout condition: treated as release, o_timeout=0.

## Test plan
- Reset then i_en=1, i_req=8'h81 -> o_gnt=8'h01, o_gnt_idx=0 one cycle later; pulse i_release -> one IDLE cycle, then o_gnt=8'h80, o_gnt_idx=7.
- i_req=8'hFF held, release after 1 grant cycle each -> grant indices 0,1,2,...,7,0 with exactly one zero-output cycle between each.
- MAX_HOLD=4, i_req=8'h04 held, no release -> o_gnt=8'h04 for exactly 4 cycles, then IDLE with o_timeout=1 for 1 cycle, then re-grant idx 2.
- Owner idx 3 drops i_req[3] while i_req[5]=1 -> grant ends next edge, o_timeout=0, next grant idx 5 after one IDLE cycle.
- i_en dropped mid-grant of idx 6 -> outputs zero after next edge, no further grants until i_en=1; then search starts at 7.
- i_rst asserted asynchronously mid-grant of idx 4 -> outputs zero without a clock edge; after release with i_req=8'h30 -> grant idx 4 (search restarts at 0).

Source files
------------

// File: rtl/arbiter_rr_8.sv
// Round-robin arbiter for 8 requesters: registered one-hot grant, release handshake,
// bounded ownership via a hold-cycle limit, and a mandatory IDLE turnaround between grants.
module arbiter_rr_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_req,
    input  logic       i_release,
    output logic [7:0] o_gnt,
    output logic [2:0] o_gnt_idx,
    output logic       o_gnt_valid,
    output logic       o_timeout,
    output logic       o_dbg_state
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    state_t            state_next;
    logic [2:0]        owner;
    logic [2:0]        ptr;
    logic [HOLD_W-1:0] hold;
    logic              timeout_q;

    logic [2:0]        winner;
    logic [2:0]        cand;
    logic              found;
    logic              owner_req;
    logic              hold_limit;
    logic              exit_grant;

    // Search upward from ptr+1; the i=8 step lands back on ptr so it is tried last.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && i_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign owner_req  = i_req[owner];
    assign hold_limit = (hold == HOLD_LAST);
    assign exit_grant = !i_en || i_release || !owner_req || hold_limit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_en && found) state_next = GRANT;
            GRANT:   if (exit_grant)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers that ride alongside the state: owner, pointer, hold count, timeout flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner     <= 3'd0;
            ptr       <= 3'd7;
            hold      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == GRANT) && i_en && !i_release && owner_req && hold_limit;
            if (state == IDLE) begin
                hold <= '0;
                if (i_en && found) begin
                    owner <= winner;
                    ptr   <= winner;
                end
            end else if (!hold_limit) begin
                hold <= hold + 1'b1;
            end
        end
    end

    always_comb begin
        o_gnt       = 8'h00;
        o_gnt_idx   = 3'd0;
        o_gnt_valid = 1'b0;
        if (state == GRANT) begin
            o_gnt       = 8'h01 << owner;
            o_gnt_idx   = owner;
            o_gnt_valid = 1'b1;
        end
        o_timeout   = timeout_q;
        o_dbg_state = state;
    end

endmodule

// File: tb/tb_arbiter_rr_8.sv
// Directed bench for arbiter_rr_8 (MAX_HOLD=4): fairness order, release, timeout,
// owner drop, enable drop and asynchronous reset, each checked against hand-derived values.
module tb_arbiter_rr_8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic       dbg_state;

    int checks   = 0;
    int failures = 0;

    arbiter_rr_8 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_req       (req),
        .i_release   (rel),
        .o_gnt       (gnt),
        .o_gnt_idx   (gnt_idx),
        .o_gnt_valid (gnt_valid),
        .o_timeout   (timeout),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                             input logic e_valid, input logic e_to);
        checks++;
        assert (gnt === e_gnt) else begin
            failures++;
            $error("FAIL %s gnt got=%h exp=%h", tag, gnt, e_gnt);
        end
        checks++;
        assert (gnt_idx === e_idx) else begin
            failures++;
            $error("FAIL %s idx got=%0d exp=%0d", tag, gnt_idx, e_idx);
        end
        checks++;
        assert (gnt_valid === e_valid) else begin
            failures++;
            $error("FAIL %s valid got=%b exp=%b", tag, gnt_valid, e_valid);
        end
        checks++;
        assert (timeout === e_to) else begin
            failures++;
            $error("FAIL %s timeout got=%b exp=%b", tag, timeout, e_to);
        end
    endtask

    task automatic check_idle(input string tag, input logic e_to);
        check_out(tag, 8'h00, 3'd0, 1'b0, e_to);
    endtask

    task automatic check_gnt(input string tag, input logic [2:0] idx);
        logic [7:0] oh;
        oh = 8'h01 << idx;
        check_out(tag, oh, idx, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        rel = 1'b0;
        #12;
        check_idle("reset", 1'b0);
        tick();
        rst = 1'b0;

        // 0x81 from reset: pointer 7 -> search starts at 0, then 7 after release.
        en  = 1'b1;
        req = 8'h81;
        tick();
        check_gnt("t1_first", 3'd0);
        rel = 1'b1;
        tick();
        check_idle("t1_turn", 1'b0);
        rel = 1'b0;
        tick();
        check_gnt("t1_second", 3'd7);
        rel = 1'b1;
        tick();
        check_idle("t1_end", 1'b0);
        rel = 1'b0;
        req = 8'h00;
        tick();
        check_idle("t1_noreq", 1'b0);

        // All requesting, one-cycle ownerships: 0..7 then wrap to 0.
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] e;
            e = 3'(k);
            tick();
            check_gnt("t2_rr", e);
            rel = 1'b1;
            tick();
            check_idle("t2_gap", 1'b0);
            rel = 1'b0;
        end
        req = 8'h00;
        tick();

        // Hold limit: exactly 4 grant cycles, then one timeout IDLE cycle, then re-grant.
        req = 8'h04;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_gnt("t3_hold", 3'd2);
        end
        tick();
        check_idle("t3_timeout", 1'b1);
        tick();
        check_gnt("t3_regrant", 3'd2);
        tick();
        check_gnt("t3_h1", 3'd2);
        tick();
        check_gnt("t3_h2", 3'd2);
        tick();
        check_gnt("t3_h3", 3'd2);
        rel = 1'b1;
        tick();
        check_idle("t3_rel_wins", 1'b0);
        rel = 1'b0;
        req = 8'h00;
        tick();
        check_idle("t3_quiet", 1'b0);

        // Owner 3 drops its request while 5 waits.
        req = 8'h28;
        tick();
        check_gnt("t4_own3", 3'd3);
        req = 8'h20;
        tick();
        check_idle("t4_drop", 1'b0);
        tick();
        check_gnt("t4_own5", 3'd5);
        rel = 1'b1;
        tick();
        check_idle("t4_end", 1'b0);
        rel = 1'b0;

        // Enable dropped mid-grant of 6; no grants while low; resumes searching at 7.
        req = 8'h40;
        tick();
        check_gnt("t5_own6", 3'd6);
        en = 1'b0;
        tick();
        check_idle("t5_en_off", 1'b0);
        req = 8'hC0;
        tick();
        check_idle("t5_blocked_a", 1'b0);
        tick();
        check_idle("t5_blocked_b", 1'b0);
        en = 1'b1;
        tick();
        check_gnt("t5_own7", 3'd7);
        rel = 1'b1;
        tick();
        check_idle("t5_end", 1'b0);
        rel = 1'b0;

        // Asynchronous reset mid-grant of 4; pointer must return to 7.
        req = 8'h10;
        tick();
        check_gnt("t6_own4", 3'd4);
        #2;
        rst = 1'b1;
        #1;
        check_idle("t6_async", 1'b0);
        req = 8'h30;
        tick();
        check_idle("t6_in_rst", 1'b0);
        #3;
        rst = 1'b0;
        tick();
        check_gnt("t6_after", 3'd4);
        rel = 1'b1;
        tick();
        check_idle("t6_end", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
